// File: rtl/jtcommando_dwnld.sv
// jtcommando_dwnld - download path from the ioctl byte stream to the SDRAM
// programming port and the on-chip colour/timing PROMs.
//
// Optional feature: define JTCOMMANDO_GFX_SWIZZLE_EN to swap byte-address
// bits 1 and 0 inside the graphics region so plane pairs share a 16-bit word.
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   downloading          high while a ROM download is in progress
//   ioctl_addr/data/wr   incoming byte stream (wr is a one-cycle strobe)
//   prog_addr/data/mask  SDRAM word address, byte, active-low byte enable
//   prog_we / prog_ack   write request held until the one-cycle acceptance
//   prom_we/addr/data    one-hot single-cycle PROM write
//   dwnld_done           one-cycle pulse once a finished download has drained
//   ovf                  sticky flag: an SDRAM byte was dropped
module jtcommando_dwnld #(
  parameter logic [21:0] GFX_START  = 22'h10000,
  parameter logic [21:0] PROM_START = 22'h3C000,
  parameter int          PROM_AW    = 8,
  parameter int          PROM_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic [21:0]           ioctl_addr,
  input  logic [7:0]            ioctl_data,
  input  logic                  ioctl_wr,
  output logic [21:0]           prog_addr,
  output logic [7:0]            prog_data,
  output logic [1:0]            prog_mask,
  output logic                  prog_we,
  input  logic                  prog_ack,
  output logic [PROM_COUNT-1:0] prom_we,
  output logic [PROM_AW-1:0]    prom_addr,
  output logic [7:0]            prom_data,
  output logic                  dwnld_done,
  output logic                  ovf
);

`ifdef JTCOMMANDO_GFX_SWIZZLE_EN
  localparam bit SWZ_EN = 1'b1;
`else
  localparam bit SWZ_EN = 1'b0;
`endif

  localparam logic [21:0] PROM_END = PROM_START + 22'(PROM_COUNT << PROM_AW);

  typedef enum logic [1:0] {IDLE, WRITE, DRAIN} state_t;

  state_t st;
  logic   dl_l, drain_pend;

  // one-entry holding buffer behind prog_*
  logic        buf_full;
  logic [21:0] buf_addr;
  logic [7:0]  buf_data;
  logic [1:0]  buf_mask;

  logic               in_sd, in_prom, sd_wr, prom_wr, dl_fall, dl_rise;
  logic [21:0]        g, swz, eff, wr_addr;
  logic [1:0]         wr_mask;
  logic [PROM_AW+1:0] poff;

  always_comb begin
    in_sd   = ioctl_addr < PROM_START;
    in_prom = !in_sd && (ioctl_addr < PROM_END);
    sd_wr   = ioctl_wr && downloading && in_sd;
    prom_wr = ioctl_wr && downloading && in_prom;
    g       = ioctl_addr - GFX_START;
    swz     = GFX_START + {g[21:2], g[0], g[1]};
    eff     = (SWZ_EN && in_sd && (ioctl_addr >= GFX_START)) ? swz : ioctl_addr;
    wr_addr = {1'b0, eff[21:1]};
    wr_mask = eff[0] ? 2'b01 : 2'b10;
    // low bits of the difference only depend on the low bits of the operands
    poff    = ioctl_addr[PROM_AW+1:0] - PROM_START[PROM_AW+1:0];
    dl_fall = dl_l && !downloading;
    dl_rise = !dl_l && downloading;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      dl_l       <= 1'b0;
      drain_pend <= 1'b0;
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_mask  <= 2'b11;
      prog_we    <= 1'b0;
      buf_full   <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      buf_mask   <= 2'b11;
      prom_we    <= '0;
      prom_addr  <= '0;
      prom_data  <= '0;
      dwnld_done <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      dl_l       <= downloading;
      dwnld_done <= 1'b0;
      prom_we    <= '0;
      if (prom_wr) begin
        prom_we   <= PROM_COUNT'(1) << poff[PROM_AW+1:PROM_AW];
        prom_addr <= poff[PROM_AW-1:0];
        prom_data <= ioctl_data;
      end
      if (dl_rise) ovf <= 1'b0;

      case (st)
        IDLE: begin
          if (dl_fall) st <= DRAIN;
          else if (sd_wr) begin
            prog_addr <= wr_addr;
            prog_data <= ioctl_data;
            prog_mask <= wr_mask;
            prog_we   <= 1'b1;
            st        <= WRITE;
          end
        end
        WRITE, DRAIN: begin
          if (st == WRITE && dl_fall) drain_pend <= 1'b1;
          if (prog_we && prog_ack) begin
            // retire current write; next byte (buffer first) follows with no gap
            if (buf_full) begin
              prog_addr <= buf_addr;
              prog_data <= buf_data;
              prog_mask <= buf_mask;
              if (sd_wr) begin
                buf_addr <= wr_addr;
                buf_data <= ioctl_data;
                buf_mask <= wr_mask;
              end else begin
                buf_full <= 1'b0;
              end
            end else if (sd_wr) begin
              prog_addr <= wr_addr;
              prog_data <= ioctl_data;
              prog_mask <= wr_mask;
            end else begin
              prog_we <= 1'b0;
            end
            if (st == WRITE) begin
              if (dl_fall || drain_pend) begin
                st         <= DRAIN;
                drain_pend <= 1'b0;
              end else if (!buf_full && !sd_wr) begin
                st <= IDLE;
              end
            end
          end else if (prog_we) begin
            if (sd_wr) begin
              if (buf_full) ovf <= 1'b1;
              else begin
                buf_addr <= wr_addr;
                buf_data <= ioctl_data;
                buf_mask <= wr_mask;
                buf_full <= 1'b1;
              end
            end
          end else if (buf_full) begin
            prog_addr <= buf_addr;
            prog_data <= buf_data;
            prog_mask <= buf_mask;
            prog_we   <= 1'b1;
            buf_full  <= 1'b0;
          end else begin
            dwnld_done <= 1'b1;
            st         <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtcommando_dwnld.sv
module tb_jtcommando_dwnld;

  localparam int unsigned PS   = 'h3C000;
  localparam int unsigned GS   = 'h10000;
  localparam int unsigned PEND = PS + 4 * 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prog_ack = 1'b0;
  logic [3:0]  prom_we;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_done;
  logic        ovf;

  jtcommando_dwnld #(.PROM_AW(8), .PROM_COUNT(4)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prog_ack(prog_ack),
    .prom_we(prom_we), .prom_addr(prom_addr), .prom_data(prom_data),
    .dwnld_done(dwnld_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending SDRAM writes form a queue of at most two
  // (the one on prog_* plus one held); everything else is plain arithmetic.
  typedef struct { logic [21:0] a; logic [7:0] d; logic [1:0] m; } ent_t;
  ent_t       q[$];
  bit         draining = 1'b0, dl_prev = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [3:0] m_prom_we = '0;
  logic [7:0] m_prom_addr = '0, m_prom_data = '0;

  always @(posedge clk or posedge rst) begin
    int unsigned a, ea, gg;
    ent_t e;
    if (rst) begin
      q.delete();
      draining = 0; dl_prev = 0; m_done = 0; m_ovf = 0; m_prom_we = '0;
    end else begin
      m_done = 0;
      if (draining && q.size() == 0) begin m_done = 1; draining = 0; end
      if (dl_prev && !downloading) draining = 1;
      if (!dl_prev && downloading) m_ovf = 0;
      if (prog_ack && q.size() > 0) void'(q.pop_front());
      m_prom_we = '0;
      if (ioctl_wr && downloading) begin
        a = int'(ioctl_addr);
        if (a < PS) begin
          ea = a;
`ifdef JTCOMMANDO_GFX_SWIZZLE_EN
          if (a >= GS) begin
            gg = a - GS;
            ea = GS + (gg & ~32'd3) + ((gg & 1) << 1) + ((gg >> 1) & 1);
          end
`endif
          e.a = 22'(ea / 2);
          e.d = ioctl_data;
          e.m = (ea % 2 == 1) ? 2'b01 : 2'b10;
          if (q.size() < 2) q.push_back(e);
          else m_ovf = 1;
        end else if (a < PEND) begin
          m_prom_we   = 4'(1 << ((a - PS) / 256));
          m_prom_addr = 8'((a - PS) % 256);
          m_prom_data = ioctl_data;
        end
      end
      dl_prev = downloading;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("prog_we", prog_we, q.size() > 0);
      if (q.size() > 0) begin
        chk("prog_addr", prog_addr, q[0].a);
        chk("prog_data", prog_data, q[0].d);
        chk("prog_mask", prog_mask, q[0].m);
      end
      chk("prom_we", prom_we, m_prom_we);
      if (m_prom_we != 0) begin
        chk("prom_addr", prom_addr, m_prom_addr);
        chk("prom_data", prom_data, m_prom_data);
      end
      chk("dwnld_done", dwnld_done, m_done);
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  function automatic logic [21:0] rand_addr();
    logic [21:0] bnd [6];
    bnd = '{22'h3BFFF, 22'h3C000, 22'h3C3FF, 22'h3C400, 22'h0FFFF, 22'h10000};
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return 22'($urandom_range(0, 'hFFFF));
      4, 5, 6:    return 22'($urandom_range('h10000, 'h3BFFF));
      7, 8:       return 22'($urandom_range('h3C000, 'h3C3FF));
      9:          return 22'($urandom_range('h3C400, 'h3FFFFF));
      default:    return bnd[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    bit got;
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_prog_mask", prog_mask, 2'b11);
    chk("rst_prog_we", prog_we, 0);
    chk("rst_prom_we", prom_we, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    downloading = 1'b1;
    tick();

    // single SDRAM byte, ack sampled on the fifth edge after capture
    send(22'h00003, 8'hA5);
    chk("t1_we", prog_we, 1);
    chk("t1_addr", prog_addr, 22'h1);
    chk("t1_mask", prog_mask, 2'b01);
    chk("t1_data", prog_data, 8'hA5);
    tick(); tick(); tick();
    chk("t1_we_held", prog_we, 1);
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    chk("t1_we_drop", prog_we, 0);

    // PROM byte
    send(22'h3C105, 8'h0F);
    chk("t2_prom_we", prom_we, 4'b0010);
    chk("t2_prom_addr", prom_addr, 8'h05);
    chk("t2_prom_data", prom_data, 8'h0F);
    chk("t2_prog_we", prog_we, 0);
    tick();
    chk("t2_prom_we_off", prom_we, 0);

    // overflow: third byte dropped
    send(22'h100, 8'h11); send(22'h101, 8'h22); send(22'h102, 8'h33);
    chk("t3_ovf", ovf, 1);
    chk("t3_data0", prog_data, 8'h11);
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    chk("t3_data1", prog_data, 8'h22);
    chk("t3_we1", prog_we, 1);
    tick();
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    chk("t3_we_end", prog_we, 0);

    // drain with one write plus one held byte; acks at +2 and +5
    send(22'h200, 8'h44); send(22'h201, 8'h55);
    downloading = 1'b0;
    tick();
    tick();
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    chk("t4_data", prog_data, 8'h55);
    chk("t4_we", prog_we, 1);
    tick(); tick();
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    chk("t4_we_end", prog_we, 0);
    chk("t4_done_early", dwnld_done, 0);
    tick();
    chk("t4_done", dwnld_done, 1);
    tick();
    chk("t4_done_once", dwnld_done, 0);
    chk("t4_ovf_sticky", ovf, 1);
    downloading = 1'b1;
    tick();
    chk("t4_ovf_clear", ovf, 0);

    // reset in the middle of a write with a full buffer and ovf set
    send(22'h300, 8'h01); send(22'h301, 8'h02); send(22'h302, 8'h03);
    chk("t5_ovf_pre", ovf, 1);
    rst = 1'b1;
    #1;
    chk("t5_we", prog_we, 0);
    chk("t5_mask", prog_mask, 2'b11);
    chk("t5_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    tick();
    chk("t5_no_we", prog_we, 0);
    chk("t5_no_done", dwnld_done, 0);

    // graphics-region address
    send(22'h10001, 8'h66);
`ifdef JTCOMMANDO_GFX_SWIZZLE_EN
    chk("t6_addr", prog_addr, 22'h8001);
    chk("t6_mask", prog_mask, 2'b10);
`else
    chk("t6_addr", prog_addr, 22'h8000);
    chk("t6_mask", prog_mask, 2'b01);
`endif
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    tick();

    // randomized sessions
    for (int s = 0; s < 30; s++) begin
      downloading = 1'b1;
      for (int c = 0; c < int'($urandom_range(20, 120)); c++) begin
        ioctl_wr   = ($urandom_range(0, 1) == 1);
        ioctl_addr = rand_addr();
        ioctl_data = 8'($urandom);
        prog_ack   = ($urandom_range(0, 2) == 0);
        tick();
      end
      ioctl_wr = 1'b0;
      downloading = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        prog_ack   = ($urandom_range(0, 2) == 0);
        ioctl_wr   = ($urandom_range(0, 3) == 0);
        ioctl_addr = rand_addr();
        ioctl_data = 8'($urandom);
        tick();
        if (dwnld_done) got = 1'b1;
      end
      ioctl_wr = 1'b0;
      prog_ack = 1'b0;
      chk("drain_done_seen", got, 1);
      tick(); tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtcommando_dwnld.md
Name: jtcommando_dwnld

Overview:
- Download-path stage between the MiST frame's ioctl byte stream and the SDRAM programming port / on-chip PROMs.
- Classifies each downloaded byte by address region:
  - Bytes below PROM_START become SDRAM byte writes on the prog_* handshake.
  - Bytes in the PROM region become single-cycle writes to one of PROM_COUNT colour/timing PROMs.
- Buffers one pending byte so ioctl bursts survive SDRAM back-pressure.
- Flags the end of download once all writes have drained.

Parameters:
- GFX_START, 22'h10000, first byte address of the graphics region; only used by the optional feature.
- PROM_START, 22'h3C000, first byte address of the PROM region.
- PROM_AW, 8, address width of each PROM; each PROM holds 2^PROM_AW bytes.
- PROM_COUNT, 4, number of PROMs, 1..4.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  reset; asynchronous, active-high.
- downloading  in  1  high while a ROM download is in progress.
- ioctl_addr  in  22  byte address of the incoming byte.
- ioctl_data  in  8  incoming byte.
- ioctl_wr  in  1  one-cycle strobe, byte valid.
- prog_addr  out  22  SDRAM word address (byte address >> 1).
- prog_data  out  8  byte to write.
- prog_mask  out  2  active-low byte enable: 2'b10 means low byte, 2'b01 means high byte.
- prog_we  out  1  write request; held until prog_ack.
- prog_ack  in  1  one-cycle SDRAM acceptance.
- prom_we  out  PROM_COUNT  one-hot, one-cycle PROM write strobe.
- prom_addr  out  PROM_AW  PROM byte address.
- prom_data  out  8  PROM byte.
- dwnld_done  out  1  one-cycle pulse when a download has fully drained.
- ovf  out  1  sticky: a byte was dropped.

Behaviour:
- Reset values: prog_addr=0, prog_data=0, prog_mask=2'b11, prog_we=0, prom_we=0, prom_addr=0, prom_data=0, dwnld_done=0, ovf=0. FSM=IDLE, buffer empty.
- Reset asserted mid-operation aborts everything. Pending bytes are lost; no done pulse.
- ioctl_wr with downloading=0 is ignored.
- Region decode, with off = ioctl_addr - PROM_START:
  - ioctl_addr < PROM_START: SDRAM byte.
  - PROM_START <= ioctl_addr < PROM_START + (PROM_COUNT << PROM_AW): PROM byte. Index = off[PROM_AW+1:PROM_AW]; prom_addr = off[PROM_AW-1:0].
  - Any higher address: discarded silently. Not counted as overflow.
- PROM path, no handshake:
  - ioctl_wr at cycle n: prom_we[idx]=1 at n+1 for exactly one cycle, with prom_addr and prom_data valid in the same cycle.
  - PROM bytes never occupy the SDRAM buffer.
- SDRAM path: FSM states IDLE, WRITE, DRAIN.
  - IDLE + SDRAM byte at n: prog_* loaded and prog_we=1 at n+1; go to WRITE.
  - WRITE: prog_we and the prog_* fields stay stable until prog_ack is sampled high; prog_we drops on the following edge.
  - On ack with buffer full: buffer moves to prog_* and prog_we stays 1 with no gap cycle; buffer empties.
  - On ack with buffer empty: go to IDLE.
  - SDRAM byte arriving in WRITE with buffer empty: captured into the buffer.
  - SDRAM byte arriving in WRITE with buffer full: dropped, ovf=1.
  - prog_ack in the same cycle as a new ioctl_wr: the ack retires the current write, the buffer (if full) advances into prog_*, and the new byte lands in the buffer. No drop.
  - prog_ack in IDLE is ignored.
- Byte lane: prog_mask = ioctl_addr[0] ? 2'b01 : 2'b10.
- End of download:
  - Falling edge of downloading moves the FSM to DRAIN (from IDLE directly; from WRITE after the current write).
  - DRAIN completes the remaining writes, then asserts dwnld_done for one cycle once prog_we=0 and the buffer is empty, and returns to IDLE.
  - If nothing is pending, dwnld_done fires one cycle after the falling edge.
- ovf clears on the rising edge of downloading.

Optional Feature:
- Macro: JTCOMMANDO_GFX_SWIZZLE_EN.
- Defined: for GFX_START <= ioctl_addr < PROM_START, with g = ioctl_addr - GFX_START, the SDRAM byte address becomes GFX_START + {g[21:2], g[0], g[1]} (bits 1 and 0 swapped) before the >>1 and lane selection. This interleaves plane pairs into one 16-bit word.
- Undefined: addresses pass through unchanged. Region decode is identical in both builds.

Test Plan:
- Byte 8'hA5 at ioctl_addr 22'h00003, prog_ack 3 cycles later -> prog_we high at n+1 for 4 cycles, with prog_addr=22'h1, prog_mask=2'b01, prog_data=8'hA5.
- ioctl_addr 22'h3C105, data 8'h0F, PROM_AW=8 -> prom_we=4'b0010, prom_addr=8'h05, prom_data=8'h0F for one cycle; prog_we stays 0.
- Three SDRAM bytes on consecutive cycles with prog_ack held low -> first in prog_*, second buffered, third dropped, ovf=1. Two acks later both written; prog_we is continuous between them.
- downloading falls while one write and one buffered byte are pending, acks at +2 and +5 -> dwnld_done pulses exactly once, one cycle after the second write retires.
- rst pulsed during WRITE -> prog_we=0, prog_mask=2'b11, buffer empty, ovf=0 immediately. A later ack produces no write and no done pulse.
- With JTCOMMANDO_GFX_SWIZZLE_EN, byte at 22'h10001 -> prog_addr=22'h8001, prog_mask=2'b10. Without it -> prog_addr=22'h8000, prog_mask=2'b01.
